// File: rtl/uart_rcv_pkg.sv
// Shared definitions for the 8N1 serial receiver: state encoding and
// the oversampling tick divider computation.
package uart_rcv_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_DATA  = 3'd2,
    ST_STOP  = 3'd3,
    ST_BREAK = 3'd4
  } state_t;

  // Rounded clk cycles per oversample tick.
  function automatic int calc_div(input int clock, input int baud, input int oversample);
    return (clock + (baud * oversample) / 2) / (baud * oversample);
  endfunction

endpackage

// File: rtl/uart_rx_tick.sv
// Free-running oversample tick divider: counts 0..DIV-1 and flags DIV-1.
module uart_rx_tick #(
  parameter int DIV = 13
) (
  input  logic clk,
  input  logic reset_n,
  output logic tick
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)         cnt <= '0;
    else if (cnt == LAST) cnt <= '0;
    else                  cnt <= cnt + 1'b1;
  end

  assign tick = (cnt == LAST);

endmodule

// File: rtl/uart_rcv.sv
// 8N1 serial receiver with oversampled mid-bit sampling and break handling.
//   state    | meaning
//   ST_IDLE  | line idle, looking for a low sample on a tick
//   ST_START | counting to mid start bit to confirm it is not a glitch
//   ST_DATA  | sampling 8 data bits, LSB first, one per bit time
//   ST_STOP  | sampling the stop bit; high delivers the byte, low is a framing error
//   ST_BREAK | line held low after a framing error; wait for it to return high
module uart_rcv
  import uart_rcv_pkg::*;
#(
  parameter int BAUD       = 115200,
  parameter int CLOCK      = 12_000_000,
  parameter int OVERSAMPLE = 8
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       rx,
  output logic [7:0] data,
  output logic       valid,
  output logic       ferr,
  output logic       busy
);

  localparam int DIV = calc_div(CLOCK, BAUD, OVERSAMPLE);
  localparam int CW  = $clog2(OVERSAMPLE);
  localparam logic [CW-1:0] HALF = CW'(OVERSAMPLE / 2);
  localparam logic [CW-1:0] LAST = CW'(OVERSAMPLE - 1);

  logic          tick;
  logic [1:0]    sync_q;
  logic          rx_s;
  state_t        state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [2:0]    bitn, bitn_n;
  logic [7:0]    shreg, shreg_n;
  logic [7:0]    data_n;
  logic          valid_n, ferr_n;

  uart_rx_tick #(.DIV(DIV)) u_tick (
    .clk     (clk),
    .reset_n (reset_n),
    .tick    (tick)
  );

  // Synchronizer resets to idle-high so reset release never looks like a start edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) sync_q <= 2'b11;
    else          sync_q <= {sync_q[0], rx};
  end

  assign rx_s = sync_q[1];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= ST_IDLE;
      cnt   <= '0;
      bitn  <= '0;
      shreg <= '0;
      data  <= '0;
      valid <= 1'b0;
      ferr  <= 1'b0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      bitn  <= bitn_n;
      shreg <= shreg_n;
      data  <= data_n;
      valid <= valid_n;
      ferr  <= ferr_n;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    bitn_n  = bitn;
    shreg_n = shreg;
    data_n  = data;
    valid_n = 1'b0;
    ferr_n  = 1'b0;
    if (tick) begin
      case (state)
        ST_IDLE: begin
          if (!rx_s) begin
            state_n = ST_START;
            cnt_n   = CW'(1);
          end
        end
        ST_START: begin
          if (cnt == HALF) begin
            cnt_n = '0;
            if (!rx_s) begin
              state_n = ST_DATA;
              bitn_n  = '0;
            end else begin
              state_n = ST_IDLE;
            end
          end else begin
            cnt_n = cnt + 1'b1;
          end
        end
        ST_DATA: begin
          if (cnt == LAST) begin
            cnt_n   = '0;
            shreg_n = {rx_s, shreg[7:1]};
            bitn_n  = bitn + 3'd1;
            if (bitn == 3'd7) state_n = ST_STOP;
          end else begin
            cnt_n = cnt + 1'b1;
          end
        end
        ST_STOP: begin
          if (cnt == LAST) begin
            cnt_n = '0;
            if (rx_s) begin
              data_n  = shreg;
              valid_n = 1'b1;
              state_n = ST_IDLE;
            end else begin
              ferr_n  = 1'b1;
              state_n = ST_BREAK;
            end
          end else begin
            cnt_n = cnt + 1'b1;
          end
        end
        ST_BREAK: begin
          if (rx_s) state_n = ST_IDLE;
        end
        default: state_n = ST_IDLE;
      endcase
    end
  end

  assign busy = (state != ST_IDLE);

endmodule

// File: tb/tb_uart_rcv.sv
// Self-checking bench for uart_rcv: serial frames driven in real time,
// received bytes compared with a queue of bytes expected from the sender.
`timescale 1ns/1ps
module tb_uart_rcv;

  localparam real CLK_NS = 10.0;
  localparam real BIT_NS = CLK_NS * 12000000.0 / 115200.0;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       rx;
  logic [7:0] data;
  logic       valid, ferr, busy;

  int chk_cnt  = 0;
  int pass_cnt = 0;

  uart_rcv #(.BAUD(115200), .CLOCK(12_000_000), .OVERSAMPLE(8)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .rx      (rx),
    .data    (data),
    .valid   (valid),
    .ferr    (ferr),
    .busy    (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Output monitor, sampled on the falling edge.
  logic [7:0] got_q[$];
  int         got_cyc[$];
  int         valid_cnt = 0, ferr_cnt = 0;
  int         overlap_cnt = 0, wide_cnt = 0, stray_data_cnt = 0;
  bit         busy_seen = 0;
  logic       prev_valid = 1'b0, prev_ferr = 1'b0, prev_rst = 1'b0;
  logic [7:0] prev_data = 8'h00;
  logic [7:0] last_good = 8'h00;

  always @(negedge clk) begin
    if (valid === 1'b1) begin
      valid_cnt++;
      got_q.push_back(data);
      got_cyc.push_back(cyc);
    end
    if (ferr === 1'b1) ferr_cnt++;
    if (valid === 1'b1 && ferr === 1'b1) overlap_cnt++;
    if ((valid === 1'b1 && prev_valid === 1'b1) || (ferr === 1'b1 && prev_ferr === 1'b1)) wide_cnt++;
    if (reset_n === 1'b1 && prev_rst === 1'b1 && data !== prev_data && valid !== 1'b1) stray_data_cnt++;
    if (busy === 1'b1) busy_seen = 1;
    prev_valid = valid;
    prev_ferr  = ferr;
    prev_data  = data;
    prev_rst   = reset_n;
  end

  task automatic send_byte(input logic [7:0] b, input real bns, input bit stop_ok);
    rx = 1'b0;
    #(bns);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      #(bns);
    end
    rx = stop_ok;
    #(bns);
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    rx      = 1'b1;
    repeat (5) @(negedge clk);
    chk_cnt++; if (data !== 8'h00) $display("FAIL reset_data: got %h expected 00", data); else pass_cnt++;
    chk_cnt++; if (valid !== 1'b0) $display("FAIL reset_valid: got %b expected 0", valid); else pass_cnt++;
    chk_cnt++; if (ferr !== 1'b0) $display("FAIL reset_ferr: got %b expected 0", ferr); else pass_cnt++;
    chk_cnt++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b expected 0", busy); else pass_cnt++;
    reset_n = 1'b1;
    repeat (40) @(negedge clk);
    chk_cnt++; if (busy !== 1'b0) $display("FAIL idle_busy: got %b expected 0", busy); else pass_cnt++;
    chk_cnt++; if (valid_cnt !== 0) $display("FAIL idle_no_valid: got %0d expected 0", valid_cnt); else pass_cnt++;
  endtask

  task automatic test_single();
    int v0, f0, n0, start_cyc, lat;
    v0 = valid_cnt; f0 = ferr_cnt; n0 = got_q.size();
    @(negedge clk); #3;
    start_cyc = cyc;
    send_byte(8'h35, BIT_NS, 1'b1);
    #(BIT_NS);
    chk_cnt++; if (valid_cnt - v0 !== 1) $display("FAIL single_count: got %0d expected 1", valid_cnt - v0); else pass_cnt++;
    chk_cnt++; if (ferr_cnt !== f0) $display("FAIL single_ferr: got %0d expected 0", ferr_cnt - f0); else pass_cnt++;
    chk_cnt++;
    if (got_q.size() <= n0 || got_q[n0] !== 8'h35)
      $display("FAIL single_data: got %h expected 35", (got_q.size() > n0) ? got_q[n0] : 8'hxx);
    else pass_cnt++;
    lat = (got_cyc.size() > n0) ? got_cyc[n0] - start_cyc : -1;
    chk_cnt++;
    if (lat < 988 || lat > 1004) $display("FAIL single_latency: got %0d clk expected 988..1004", lat);
    else pass_cnt++;
    last_good = 8'h35;
  endtask

  task automatic test_stream();
    int n0;
    logic [7:0] b;
    n0 = got_q.size();
    for (int i = 0; i < 10; i++) begin
      b = 8'(8'h30 + i);
      send_byte(b, BIT_NS, 1'b1);
    end
    #(2 * BIT_NS);
    chk_cnt++; if (got_q.size() - n0 !== 10) $display("FAIL stream_count: got %0d expected 10", got_q.size() - n0); else pass_cnt++;
    for (int i = 0; i < 10; i++) begin
      b = 8'(8'h30 + i);
      chk_cnt++;
      if (got_q.size() <= n0 + i || got_q[n0 + i] !== b)
        $display("FAIL stream_byte%0d: got %h expected %h", i, (got_q.size() > n0 + i) ? got_q[n0 + i] : 8'hxx, b);
      else pass_cnt++;
    end
    last_good = 8'h39;
  endtask

  task automatic test_glitch();
    int v0, f0;
    v0 = valid_cnt; f0 = ferr_cnt;
    @(negedge clk);
    busy_seen = 0;
    rx = 1'b0;
    repeat (20) @(negedge clk);
    rx = 1'b1;
    repeat (110) @(negedge clk);
    chk_cnt++; if (busy_seen !== 1'b1) $display("FAIL glitch_busy_rose: got %b expected 1", busy_seen); else pass_cnt++;
    chk_cnt++; if (busy !== 1'b0) $display("FAIL glitch_busy_fell: got %b expected 0", busy); else pass_cnt++;
    chk_cnt++; if (valid_cnt !== v0) $display("FAIL glitch_valid: got %0d expected 0", valid_cnt - v0); else pass_cnt++;
    chk_cnt++; if (ferr_cnt !== f0) $display("FAIL glitch_ferr: got %0d expected 0", ferr_cnt - f0); else pass_cnt++;
  endtask

  task automatic test_break();
    int v0, f0, n0;
    v0 = valid_cnt; f0 = ferr_cnt;
    send_byte(8'h55, BIT_NS, 1'b0);
    #(30 * BIT_NS);
    chk_cnt++; if (ferr_cnt - f0 !== 1) $display("FAIL break_ferr: got %0d expected 1", ferr_cnt - f0); else pass_cnt++;
    chk_cnt++; if (valid_cnt !== v0) $display("FAIL break_valid: got %0d expected 0", valid_cnt - v0); else pass_cnt++;
    chk_cnt++; if (data !== last_good) $display("FAIL break_data_held: got %h expected %h", data, last_good); else pass_cnt++;
    chk_cnt++; if (busy !== 1'b1) $display("FAIL break_busy: got %b expected 1", busy); else pass_cnt++;
    rx = 1'b1;
    #(2 * BIT_NS);
    chk_cnt++; if (busy !== 1'b0) $display("FAIL break_exit_busy: got %b expected 0", busy); else pass_cnt++;
    n0 = got_q.size();
    send_byte(8'hA3, BIT_NS, 1'b1);
    #(BIT_NS);
    chk_cnt++;
    if (got_q.size() - n0 !== 1 || got_q[n0] !== 8'hA3)
      $display("FAIL after_break_data: got %0d bytes, first %h expected 1 byte A3", got_q.size() - n0, (got_q.size() > n0) ? got_q[n0] : 8'hxx);
    else pass_cnt++;
    chk_cnt++; if (ferr_cnt - f0 !== 1) $display("FAIL after_break_ferr: got %0d expected 1", ferr_cnt - f0); else pass_cnt++;
    last_good = 8'hA3;
  endtask

  task automatic test_reset_midframe();
    int v0, n0;
    logic [7:0] b, b2;
    b  = 8'($urandom);
    b2 = 8'($urandom);
    v0 = valid_cnt;
    fork
      send_byte(b, BIT_NS, 1'b1);
      begin
        #(5.5 * BIT_NS);
        reset_n = 1'b0;
        #1;
        chk_cnt++; if (data !== 8'h00) $display("FAIL midreset_data: got %h expected 00", data); else pass_cnt++;
        chk_cnt++; if (valid !== 1'b0) $display("FAIL midreset_valid: got %b expected 0", valid); else pass_cnt++;
        chk_cnt++; if (ferr !== 1'b0) $display("FAIL midreset_ferr: got %b expected 0", ferr); else pass_cnt++;
        chk_cnt++; if (busy !== 1'b0) $display("FAIL midreset_busy: got %b expected 0", busy); else pass_cnt++;
      end
    join
    @(negedge clk);
    reset_n = 1'b1;
    #(BIT_NS);
    chk_cnt++; if (valid_cnt !== v0) $display("FAIL midreset_no_valid: got %0d expected 0", valid_cnt - v0); else pass_cnt++;
    n0 = got_q.size();
    send_byte(b2, BIT_NS, 1'b1);
    #(BIT_NS);
    chk_cnt++;
    if (got_q.size() - n0 !== 1 || got_q[n0] !== b2)
      $display("FAIL midreset_next: got %0d bytes, first %h expected 1 byte %h", got_q.size() - n0, (got_q.size() > n0) ? got_q[n0] : 8'hxx, b2);
    else pass_cnt++;
    last_good = b2;
  endtask

  task automatic test_baud_tolerance();
    int n0;
    real scale;
    for (int s = 0; s < 2; s++) begin
      scale = (s == 0) ? 1.02 : 0.98;
      n0 = got_q.size();
      send_byte(8'hC6, BIT_NS * scale, 1'b1);
      #(BIT_NS);
      chk_cnt++;
      if (got_q.size() - n0 !== 1 || got_q[n0] !== 8'hC6)
        $display("FAIL baud_x%0.2f: got %0d bytes, first %h expected 1 byte C6", scale, got_q.size() - n0, (got_q.size() > n0) ? got_q[n0] : 8'hxx);
      else pass_cnt++;
    end
    last_good = 8'hC6;
  endtask

  task automatic test_random();
    logic [7:0] exp_q[$];
    int n0, f0, exp_ferr, skew;
    logic [7:0] b;
    real bns;
    bit bad;
    n0 = got_q.size(); f0 = ferr_cnt; exp_ferr = 0;
    for (int k = 0; k < 12; k++) begin
      b    = 8'($urandom);
      skew = int'($urandom_range(0, 30)) - 15;
      bns  = BIT_NS * (1.0 + skew / 1000.0);
      bad  = ($urandom_range(0, 5) == 0);
      send_byte(b, bns, !bad);
      if (bad) begin
        #($urandom_range(1, 3) * bns);
        rx = 1'b1;
        #(bns);
        exp_ferr++;
      end else begin
        exp_q.push_back(b);
      end
      #($urandom_range(0, 2) * bns);
    end
    #(BIT_NS);
    chk_cnt++; if (got_q.size() - n0 !== exp_q.size()) $display("FAIL random_count: got %0d expected %0d", got_q.size() - n0, exp_q.size()); else pass_cnt++;
    chk_cnt++; if (ferr_cnt - f0 !== exp_ferr) $display("FAIL random_ferr: got %0d expected %0d", ferr_cnt - f0, exp_ferr); else pass_cnt++;
    for (int i = 0; i < exp_q.size(); i++) begin
      chk_cnt++;
      if (got_q.size() <= n0 + i || got_q[n0 + i] !== exp_q[i])
        $display("FAIL random_byte%0d: got %h expected %h", i, (got_q.size() > n0 + i) ? got_q[n0 + i] : 8'hxx, exp_q[i]);
      else pass_cnt++;
    end
    if (exp_q.size() > 0) last_good = exp_q[exp_q.size() - 1];
    chk_cnt++; if (data !== last_good) $display("FAIL random_data_held: got %h expected %h", data, last_good); else pass_cnt++;
  endtask

  task automatic test_protocol();
    chk_cnt++; if (overlap_cnt !== 0) $display("FAIL valid_ferr_overlap: got %0d expected 0", overlap_cnt); else pass_cnt++;
    chk_cnt++; if (wide_cnt !== 0) $display("FAIL pulse_width: got %0d wide pulses expected 0", wide_cnt); else pass_cnt++;
    chk_cnt++; if (stray_data_cnt !== 0) $display("FAIL data_without_valid: got %0d changes expected 0", stray_data_cnt); else pass_cnt++;
  endtask

  initial begin
    #(90000 * CLK_NS);
    $display("FAIL watchdog: run still active at 90000 clk, expected completion earlier");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_single();
    test_stream();
    test_glitch();
    test_break();
    test_reset_midframe();
    test_baud_tolerance();
    test_random();
    test_protocol();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
